// File: rtl/bch_check_pkg.sv
// Shared types and helpers for the BCH loopback checker: watchdog states, queue entry layout
// and the saturating counter increment.
package bch_check_pkg;

  typedef enum logic [1:0] {
    WdIdle    = 2'd0,
    WdWait    = 2'd1,
    WdExpired = 2'd2
  } wd_state_e;

  localparam int unsigned MaxCntW = 32;

  // Queue entry is {uncorr, data}: data in the low bits, uncorr flag directly above it.
  localparam int unsigned EntryDataLsb = 0;

  function automatic int unsigned entry_uncorr_bit(input int unsigned data_bits);
    return data_bits;
  endfunction

  function automatic int unsigned entry_width(input int unsigned data_bits);
    return data_bits + 1;
  endfunction

  function automatic logic [MaxCntW-1:0] sat_inc(input logic [MaxCntW-1:0] val,
                                                 input int unsigned width);
    logic [MaxCntW-1:0] max_val;
    max_val = {MaxCntW{1'b1}} >> (MaxCntW - width);
    return (val >= max_val) ? val : val + MaxCntW'(1);
  endfunction

endpackage

// File: rtl/bch_check_fifo.sv
// Circular buffer holding words in flight between encoder input and decoder output.
// Head entry is read combinationally; a push while full is only taken alongside a pop.
module bch_check_fifo #(
  parameter int unsigned Width = 129,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            srst_ni,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0] count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_ni || clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bch_loopback_checker.sv
// Loopback self-check: queues words at the encoder input, compares them with decoder output,
// keeps saturating statistics, sticky fault flags and a no-progress watchdog.
module bch_loopback_checker
  import bch_check_pkg::*;
#(
  parameter int unsigned DATA_BITS = 128,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_uncorr,
  input  logic                 rx_valid,
  input  logic [DATA_BITS-1:0] rx_data,
  output logic                 tx_ready,
  output logic                 chk_valid,
  output logic                 chk_match,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [CNT_W-1:0]     uncorr_cnt,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 timeout,
  output logic                 fault
);

  localparam int unsigned EntryW    = entry_width(DATA_BITS);
  localparam int unsigned UncorrBit = entry_uncorr_bit(DATA_BITS);
  localparam int unsigned OccW      = $clog2(DEPTH + 1);
  localparam int unsigned TimerW    = $clog2(TIMEOUT);

  logic                 fifo_full, fifo_empty;
  logic [EntryW-1:0]    head;
  logic [OccW-1:0]      occ, occ_next;
  logic [DATA_BITS-1:0] head_data;
  logic                 head_uncorr;
  logic                 do_pop, push_acc, is_match, soft_rst;

  bch_check_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .srst_ni (reset),
    .clear_i (clear),
    .push_i  (tx_valid),
    .pop_i   (rx_valid),
    .wdata_i ({tx_uncorr, tx_data}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .rdata_o (head),
    .count_o (occ)
  );

  assign head_data   = head[UncorrBit-1:EntryDataLsb];
  assign head_uncorr = head[UncorrBit];
  assign do_pop      = rx_valid & ~fifo_empty;
  assign push_acc    = tx_valid & (~fifo_full | do_pop);
  assign is_match    = (rx_data == head_data);
  assign soft_rst    = ~reset | clear;
  assign tx_ready    = ~fifo_full;

  always_comb begin
    occ_next = occ;
    if (push_acc && !do_pop) begin
      occ_next = occ + OccW'(1);
    end else if (do_pop && !push_acc) begin
      occ_next = occ - OccW'(1);
    end
  end

  // Compare stage, statistics and sticky flags.
  logic             chk_valid_q, chk_match_q;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, uncorr_q, uncorr_d;
  logic             overflow_q, underflow_q, fault_q;

  always_comb begin
    pass_d   = pass_q;
    fail_d   = fail_q;
    uncorr_d = uncorr_q;
    if (do_pop) begin
      if (head_uncorr) begin
        uncorr_d = CNT_W'(sat_inc(MaxCntW'(uncorr_q), CNT_W));
      end else if (is_match) begin
        pass_d = CNT_W'(sat_inc(MaxCntW'(pass_q), CNT_W));
      end else begin
        fail_d = CNT_W'(sat_inc(MaxCntW'(fail_q), CNT_W));
      end
    end
  end

  // Watchdog state, timer and sticky timeout flag.
  wd_state_e         wd_q;
  logic [TimerW-1:0] timer_q;
  logic              timeout_q;

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      chk_valid_q <= 1'b0;
      chk_match_q <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
      uncorr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      chk_valid_q <= do_pop;
      chk_match_q <= do_pop & is_match;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      uncorr_q    <= uncorr_d;
      if (tx_valid && fifo_full && !do_pop) overflow_q <= 1'b1;
      if (rx_valid && fifo_empty)           underflow_q <= 1'b1;
      fault_q     <= (fail_q != '0) | overflow_q | underflow_q | timeout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      wd_q      <= WdIdle;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (wd_q)
        WdIdle, WdWait: begin
          if (occ_next == '0) begin
            wd_q    <= WdIdle;
            timer_q <= '0;
          end else if (wd_q == WdIdle || rx_valid) begin
            wd_q    <= WdWait;
            timer_q <= '0;
          end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
            wd_q      <= WdExpired;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        default: begin
          // Expired: hold until reset or clear.
          wd_q <= WdExpired;
        end
      endcase
    end
  end

  assign chk_valid  = chk_valid_q;
  assign chk_match  = chk_match_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign uncorr_cnt = uncorr_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign timeout    = timeout_q;
  assign fault      = fault_q;

endmodule
